// File: rtl/register_file_scm_pkg.sv
// register_file_scm_pkg: shared types and helpers for the clearable latch register file.
package register_file_scm_pkg;
  typedef enum logic [1:0] {CLEAR, DRAIN, IDLE} scm_clr_state_e;
  function automatic int numBytes(input int dataWidth);
    return dataWidth / 8;
  endfunction
endpackage

// File: rtl/register_file_scm_row.sv
// register_file_scm_row: one row of byte-sliced latches, each byte behind its own clock gate.
module cluster_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);
  logic enLatch;
  always_latch if (!clk_i) enLatch <= en_i | test_en_i;
  assign clk_o = clk_i & enLatch;
endmodule

module register_file_scm_row
  import register_file_scm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             test_en_i,
  input  logic                             rowSel,
  input  logic [numBytes(DATA_WIDTH)-1:0]  byteEn,
  input  logic [DATA_WIDTH-1:0]            writeData,
  output logic [DATA_WIDTH-1:0]            rowData
);
  genvar b;
  for (b = 0; b < numBytes(DATA_WIDTH); b++) begin : g_byte
    logic       gclk;
    logic [7:0] byteQ;
    cluster_clock_gating u_cg (
      .clk_i    (clk),
      .en_i     (rowSel & byteEn[b]),
      .test_en_i(test_en_i),
      .clk_o    (gclk)
    );
    always_latch if (gclk) byteQ <= writeData[8*b +: 8];
    assign rowData[8*b +: 8] = byteQ;
  end
endmodule

// File: rtl/register_file_1r_1w_scm_clr.sv
// register_file_1r_1w_scm_clr: latch-based 1R1W register file with a hardware clear sweep.
module register_file_1r_1w_scm_clr
  import register_file_scm_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_WORDS  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            test_en_i,
  input  logic                            ReadEnable,
  input  logic [ADDR_WIDTH-1:0]           ReadAddr,
  output logic [DATA_WIDTH-1:0]           ReadData,
  input  logic                            WriteEnable,
  input  logic [ADDR_WIDTH-1:0]           WriteAddr,
  input  logic [DATA_WIDTH-1:0]           WriteData,
  input  logic [numBytes(DATA_WIDTH)-1:0] WriteBE,
  input  logic                            ClearReq,
  output logic                            Busy
);
  localparam int NUM_BYTES = numBytes(DATA_WIDTH);
  scm_clr_state_e state, stateNext;
  logic [ADDR_WIDTH-1:0] counter, readAddrQ;
  logic [DATA_WIDTH-1:0] writeDataQ, readMux;
  logic [DATA_WIDTH-1:0] rowData [NUM_WORDS];
  logic [NUM_WORDS-1:0]  rowSel;
  logic [NUM_BYTES-1:0]  byteEn;
  logic clearing, clearStart, writeOk;
  assign Busy       = state != IDLE;
  assign clearing   = state == CLEAR;
  assign clearStart = !Busy && ClearReq;
  assign writeOk    = !Busy && !ClearReq && WriteEnable &&
                      ({1'b0, WriteAddr} < (ADDR_WIDTH+1)'(NUM_WORDS));
  assign byteEn     = clearing ? '1 : WriteBE;
  always_comb begin
    stateNext = state;
    if (clearing && counter == ADDR_WIDTH'(NUM_WORDS-1)) stateNext = DRAIN;
    else if (state == DRAIN) stateNext = IDLE;
    else if (clearStart) stateNext = CLEAR;
  end
  // Gate enables are combinational so the pulse lands in the high phase right after the
  // sampling edge, while the data flop already holds the value the latches must take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      counter    <= '0;
      readAddrQ  <= '0;
      writeDataQ <= '0;
    end else begin
      state      <= stateNext;
      counter    <= clearing ? counter + ADDR_WIDTH'(1) : clearStart ? '0 : counter;
      readAddrQ  <= (!Busy && ReadEnable) ? ReadAddr : readAddrQ;
      writeDataQ <= clearing ? '0 : writeOk ? WriteData : writeDataQ;
    end
  end
  genvar r;
  for (r = 0; r < NUM_WORDS; r++) begin : g_row
    assign rowSel[r] = clearing ? counter == ADDR_WIDTH'(r) : writeOk && WriteAddr == ADDR_WIDTH'(r);
    register_file_scm_row #(.DATA_WIDTH(DATA_WIDTH)) u_row (
      .clk      (clk),
      .test_en_i(test_en_i),
      .rowSel   (rowSel[r]),
      .byteEn   (byteEn),
      .writeData(writeDataQ),
      .rowData  (rowData[r])
    );
  end
  always_comb begin
    readMux = '0;
    for (int i = 0; i < NUM_WORDS; i++) readMux = (readAddrQ == ADDR_WIDTH'(i)) ? rowData[i] : readMux;
  end
  assign ReadData = Busy ? '0 : readMux;
endmodule

// File: tb/tb_register_file_1r_1w_scm_clr.sv
// tb_register_file_1r_1w_scm_clr: randomized scoreboard bench against an array-level model.
module tb_register_file_1r_1w_scm_clr;
  localparam int AW = 5;
  localparam int N  = 32;
  logic clk = 0, rst = 1, test_en_i = 0;
  logic ReadEnable = 0, WriteEnable = 0, ClearReq = 0, Busy;
  logic [AW-1:0] ReadAddr = '0, WriteAddr = '0;
  logic [31:0] ReadData, WriteData = '0;
  logic [3:0] WriteBE = '0;

  register_file_1r_1w_scm_clr #(.ADDR_WIDTH(AW), .NUM_WORDS(N), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .test_en_i(test_en_i),
    .ReadEnable(ReadEnable), .ReadAddr(ReadAddr), .ReadData(ReadData),
    .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteBE(WriteBE),
    .ClearReq(ClearReq), .Busy(Busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [31:0] data; logic busy;} exp_t;
  exp_t q[$];
  exp_t e;
  int passed = 0, total = 0;

  // Reference model: plain row array, remaining-busy edge count and last captured read row.
  logic [31:0] mem [N];
  int busyLeft, raddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input logic we, input int wa, input logic [31:0] wd, input logic [3:0] be,
                      input logic re, input int ra, input logic clr);
    logic busyE;
    WriteEnable = we; WriteAddr = AW'(wa); WriteData = wd; WriteBE = be;
    ReadEnable = re; ReadAddr = AW'(ra); ClearReq = clr;
    if (busyLeft > 0) busyLeft--;
    else begin
      if (re) raddr = ra;
      if (clr) begin
        foreach (mem[i]) mem[i] = '0;
        busyLeft = N + 1;
      end else if (we)
        for (int b = 0; b < 4; b++) if (be[b]) mem[wa][8*b +: 8] = wd[8*b +: 8];
    end
    busyE = busyLeft > 0;
    q.push_back('{cyc + 1, busyE ? 32'h0 : mem[raddr], busyE});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk); #1;
    rst = 1;
    WriteEnable = 0; ReadEnable = 0; ClearReq = 0;
    #1;
    check("reset Busy", {31'b0, Busy}, 32'd1);
    check("reset ReadData", ReadData, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    foreach (mem[i]) mem[i] = '0;
    busyLeft = N + 1;
    raddr = 0;
  endtask

  task automatic countBusy();
    int n = 0;
    do begin idle(); n++; end while (Busy && n < 100);
    check("busy edges", n, N + 1);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      total++;
      $display("FAIL stale expectation: tag %0d at cycle %0d", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check("ReadData", ReadData, e.data);
      check("Busy", {31'b0, Busy}, {31'b0, e.busy});
    end
  end

  initial begin
    doReset();
    countBusy();
    foreach (mem[i]) check("model clear", mem[i], 32'h0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 17, 0);
    step(0, 0, 0, 0, 1, 31, 0);
    step(1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0);
    @(negedge clk); #1;
    check("row5 full write", ReadData, 32'hDEADBEEF);
    step(0, 0, 0, 0, 1, 4, 0);
    step(0, 0, 0, 0, 1, 6, 0);
    step(0, 0, 0, 0, 1, 5, 0);
    step(1, 5, 32'h11223344, 4'b0101, 0, 0, 0);
    @(negedge clk); #1;
    check("row5 byte write", ReadData, 32'hDE22BE44);
    step(1, 9, 32'hA5A5A5A5, 4'hF, 1, 9, 0);
    @(negedge clk); #1;
    check("row9 write-first", ReadData, 32'hA5A5A5A5);
    for (int i = 0; i < N; i++) step(1, i, $urandom, 4'hF, 1, i, 0);
    step(1, 3, 32'h12345678, 4'hF, 1, 3, 1);
    for (int i = 0; i < N + 2; i++) step(1, $urandom_range(0, N-1), $urandom, 4'hF, 1, $urandom_range(0, N-1), 0);
    for (int i = 0; i < N; i++) step(0, 0, 0, 0, 1, i, 0);
    doReset();
    repeat (10) idle();
    doReset();
    countBusy();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, N-1), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 1), $urandom_range(0, N-1), $urandom_range(0, 49) == 0);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL scoreboard drain: %0d left, 0 required", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/register_file_1r_1w_scm_clr.md
Name: register_file_1r_1w_scm_clr

Overview:
- Multi-row, latch-based standard-cell memory (SCM) with one read port and one write port.
- Generalises the single-row latch register file to NUM_WORDS rows, with per-byte write enables and a registered read address.
- Adds a hardware clear sweep that zeroes every row after reset release or on request.
- Used as a small low-power buffer or register bank inside cluster IPs. Writes use per-row gated clocks driving latches.

Parameters:
- ADDR_WIDTH, 5, address bits.
- NUM_WORDS, 2**ADDR_WIDTH, rows implemented; must satisfy 2 <= NUM_WORDS <= 2**ADDR_WIDTH.
- DATA_WIDTH, 32, bits per row; must be a multiple of 8.
- NUM_BYTES, DATA_WIDTH/8, derived; not overridable.

Ports:
- clk  in  1  clock; all flops on the rising edge; latches open while the gated clock is high.
- rst  in  1  asynchronous, active-high reset.
- test_en_i  in  1  forwarded to every clock-gating cell.
- ReadEnable  in  1  when high, ReadAddr is captured at the rising edge.
- ReadAddr  in  ADDR_WIDTH  read row.
- ReadData  out  DATA_WIDTH  contents of the row selected by the registered read address.
- WriteEnable  in  1  write request.
- WriteAddr  in  ADDR_WIDTH  write row.
- WriteData  in  DATA_WIDTH  write data.
- WriteBE  in  NUM_BYTES  per-byte write enable.
- ClearReq  in  1  single-cycle request to zero all rows.
- Busy  out  1  clear sweep in progress; requests are ignored while high.

Behaviour:
- Reset (asserted):
  - All flops clear: read address reg = 0, sampled write regs = 0, sweep counter = 0, FSM = CLEAR.
  - Busy = 1, ReadData = 0.
  - Latch contents are undefined.
- FSM states: CLEAR, DRAIN, IDLE.
  - CLEAR: each cycle, zero with all byte enables set is written to row[counter], and the counter increments. When counter == NUM_WORDS-1, the next state is DRAIN.
  - DRAIN: one cycle so the final latched write completes; next state is IDLE.
  - IDLE: if ClearReq is sampled high, counter = 0 and the next state is CLEAR.
- Busy = 1 in CLEAR and DRAIN. After rst falls, Busy stays high for exactly NUM_WORDS+1 rising edges.
- ReadData is forced to 0 while Busy = 1.
- Write path:
  - Edge E0 in IDLE with WriteEnable = 1 and WriteAddr < NUM_WORDS: WriteAddr, WriteData and WriteBE are sampled.
  - During the high phase after E0, the gated clock of each selected byte of that row pulses and the latches take the sampled data.
  - A 1-cycle write latency is fixed.
  - WriteBE = 0 gates no clock; the row is unchanged.
- Read path:
  - ReadEnable = 1 at edge E0 loads the read address reg.
  - ReadData is the combinational mux of the latch array; valid and stable before E0+1.
  - With ReadEnable = 0, the address reg holds; ReadData keeps following that row's contents.
- Read-during-write, same address at the same edge: ReadData shows the new data before the next edge (write-first).
- Out of range:
  - WriteAddr >= NUM_WORDS: write dropped, no clock pulses.
  - Registered read address >= NUM_WORDS: ReadData = 0.
- Arbitration and reset interactions:
  - WriteEnable or ReadEnable while Busy = 1: ignored; the read address reg holds.
  - ClearReq while Busy = 1: ignored; the sweep does not restart.
  - ClearReq and WriteEnable at the same IDLE edge: clear wins, write dropped.
  - rst asserted mid-sweep or mid-write: immediate return to the reset state; a full sweep follows release.
- Clock gating:
  - One cluster_clock_gating cell per (row, byte), enabled by decoded write-select AND byte enable.
  - No free-running clock reaches the latches.
  - Sampled write data is held in flops, so latch inputs are stable while transparent.

Decomposition:
- Package register_file_scm_pkg:
  - FSM state enum scm_clr_state_e {CLEAR, DRAIN, IDLE}.
  - Helper function for the NUM_BYTES derivation.
- Sub-module register_file_scm_row: one row of DATA_WIDTH byte-sliced latches plus their NUM_BYTES clock-gating cells.
- The top level holds the FSM, counter, sample regs, decoders and read mux.

Test Plan:
- Reset then release with NUM_WORDS=32: Busy high for exactly 33 edges; afterwards, reading rows 0, 17 and 31 each returns 0x00000000.
- Write 0xDEADBEEF to row 5 with WriteBE=4'hF, then read row 5 one cycle later -> 0xDEADBEEF; row 4 and row 6 still read 0.
- Row 5 = 0xDEADBEEF; write 0x11223344 with WriteBE=4'b0101 -> row 5 reads 0xDE22BE44.
- Same edge: write 0xA5A5A5A5 to row 9 and read row 9 -> ReadData = 0xA5A5A5A5 before the next edge.
- Fill all rows, then pulse ClearReq together with a write to row 3 -> write dropped; Busy high NUM_WORDS+1 cycles; all rows read 0; writes during Busy have no effect.
- Assert rst at sweep counter = 10, then release -> a full sweep restarts; Busy lasts 33 edges; ReadData = 0 throughout.
